led_scan_driver: RTL and testbench
==================================

LED_SCAN_DRIVER -- requirements
Module: led_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, sets the number of multiplexed digits (2..16).
REQ-002 Parameter SEG_W, default 8, sets segment bits per digit; bit SEG_W-1 is the decimal point.
REQ-003 Parameter SLOT_CYC, default 12500, sets the clk cycles each digit is addressed (>= DEAD_CYC+2).
REQ-004 Parameter DEAD_CYC, default 2, sets the anti-ghosting blank cycles at the start of each slot (< SLOT_CYC).
REQ-005 Parameter BRIGHT_W, default 4, sets the brightness code width.
REQ-006 Port clk, input, 1, is the single system clock; all logic SHALL be clocked on its rising edge.
REQ-007 Port rst_n, input, 1, is the reset: asynchronous, active-low.
REQ-008 Port enable, input, 1: high runs the scan; low blanks the display.
REQ-009 Port seg_in, input, NUM_DIGITS*SEG_W: digit k occupies bits [k*SEG_W +: SEG_W]; segments are active-low.
REQ-010 Port dp_mask, input, NUM_DIGITS: bit k high forces digit k's DP segment on (bit low).
REQ-011 Port blank_mask, input, NUM_DIGITS: bit k high blanks digit k (all segments off).
REQ-012 Port brightness, input, BRIGHT_W: PWM duty code.
REQ-013 Port seg_out, output, SEG_W: active-low segment drive.
REQ-014 Port digit_sel, output, NUM_DIGITS: one-hot-or-zero, active-high digit enable.
REQ-015 Port frame_tick, output, 1: one-cycle pulse per completed scan frame.

Function
REQ-016 A slot counter SHALL count 0..SLOT_CYC-1 and wrap; at wrap, digit index SHALL advance 0..NUM_DIGITS-1 and wrap to 0.
REQ-017 At slot count 0, seg_in slice, dp_mask bit and blank_mask bit for the current index SHALL be captured; changes mid-slot SHALL have no effect until the next slot.
REQ-018 Captured pattern: blank bit high -> all ones; otherwise the slice with bit SEG_W-1 cleared if the dp bit is high.
REQ-019 A PWM counter of BRIGHT_W bits SHALL restart at 0 at slot count DEAD_CYC and increment every cycle, wrapping freely.
REQ-020 Digit drive SHALL be on when slot count >= DEAD_CYC and (brightness == all-ones or PWM count < brightness); brightness 0 SHALL keep the digit dark.
REQ-021 When drive is on: digit_sel = one-hot of index, seg_out = captured pattern; otherwise digit_sel = 0 and seg_out = all ones.
REQ-022 All outputs SHALL be registered, lagging internal state by exactly one clk.
REQ-023 frame_tick SHALL assert for one cycle, registered, on the cycle after the index wraps NUM_DIGITS-1 -> 0.
REQ-024 enable low SHALL synchronously clear the slot counter, index and PWM counter and force blank outputs; scanning SHALL resume at index 0, slot count 0 on the first cycle enable is high.
REQ-025 digit_sel SHALL never have more than one bit set, including across slot boundaries and enable edges.

Reset
REQ-026 While rst_n is low: seg_out = all ones, digit_sel = 0, frame_tick = 0, all counters and captured state = 0.
REQ-027 After rst_n deassertion with enable high, the first slot SHALL be index 0 starting at slot count 0; reset mid-slot SHALL abort the slot immediately.

Structure
REQ-028 A shared package SHALL hold the blank pattern constant, the DP bit position, and a function deriving counter widths via clog2 of SLOT_CYC and NUM_DIGITS.
REQ-029 The prescaler/slot counter SHALL be a separate sub-module, scan_timer, outputting slot count, slot_start and index_wrap.

Verification (NUM_DIGITS=4, SEG_W=8, SLOT_CYC=8, DEAD_CYC=1, BRIGHT_W=2)
REQ-030 Reset, enable=1, brightness=3, seg_in=0xF9A4B0C0 -> digit_sel 0001/0010/0100/1000 each on for 7 of 8 cycles, seg_out C0,B0,A4,F9 respectively; frame_tick once per 32 cycles.
REQ-031 brightness=1 -> each digit on 1 of every 4 cycles after dead cycle; brightness=0 -> digit_sel stays 0, seg_out stays FF.
REQ-032 dp_mask=0100, blank_mask=0001 -> digit 2 shows A4 with bit 7 cleared (24); digit 0 slot shows FF with digit_sel 0001 still asserted.
REQ-033 seg_in changed at slot count 4 of digit 1 -> seg_out unchanged until digit 2 slot; digit 1 shows new value next frame.
REQ-034 enable dropped mid-slot of digit 2 for 3 cycles -> outputs blank next cycle; on re-enable scan restarts at digit 0, no frame_tick emitted for the aborted frame.
REQ-035 rst_n pulsed low mid-slot -> outputs FF/0000 asynchronously; all cycles checked for one-hot-or-zero digit_sel.

Source files
------------

// File: rtl/led_scan_driver_pkg.sv
// Shared constants and width helpers for the multiplexed LED scan driver.
// Segments are active-low, so "off" is a logic one.
package led_scan_driver_pkg;

  localparam logic SEG_OFF = 1'b1;

  function automatic int dp_pos(input int seg_w);
    return seg_w - 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_scan_driver_scan_timer.sv
// Slot prescaler and digit index counter for the LED scan driver.
// Both counters hold at zero while enable is low.
module scan_timer
  import led_scan_driver_pkg::*;
#(
  parameter int SLOT_CYC   = 12500,
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = cnt_w(SLOT_CYC),
  parameter int IDX_W      = cnt_w(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [CNT_W-1:0] slot_cnt,
  output logic [IDX_W-1:0] idx,
  output logic             slot_start,
  output logic             index_wrap
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slot_end;

  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign slot_cnt   = cnt_q;
  assign idx        = idx_q;
  assign slot_start = enable && (cnt_q == '0);
  assign index_wrap = enable && slot_end && (idx_q == IDX_LAST);

endmodule

// File: rtl/led_scan_driver.sv
// Multiplexed 7-segment scan driver with dead-time blanking and PWM dimming.
// All outputs are registered one cycle behind the scan state.
module led_scan_driver
  import led_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 8,
  parameter int SLOT_CYC   = 12500,
  parameter int DEAD_CYC   = 2,
  parameter int BRIGHT_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       dp_mask,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  input  logic [BRIGHT_W-1:0]         brightness,
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic                        frame_tick
);

  localparam int CNT_W  = cnt_w(SLOT_CYC);
  localparam int IDX_W  = cnt_w(NUM_DIGITS);
  localparam int DP_BIT = dp_pos(SEG_W);
  localparam logic [CNT_W-1:0] DEAD_V = CNT_W'(DEAD_CYC);
  localparam logic [SEG_W-1:0] BLANK  = {SEG_W{SEG_OFF}};

  logic [CNT_W-1:0]      slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  slot_start;
  logic                  index_wrap;

  logic [SEG_W-1:0]      slice, fresh;
  logic                  dp_bit, bl_bit;
  logic [SEG_W-1:0]      pat_q, pat_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d, pwm_now;
  logic                  wrap_q, wrap_d;
  logic                  drive;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  tick_q, tick_d;

  scan_timer #(
    .SLOT_CYC   (SLOT_CYC),
    .NUM_DIGITS (NUM_DIGITS),
    .CNT_W      (CNT_W),
    .IDX_W      (IDX_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .slot_cnt   (slot_cnt),
    .idx        (idx),
    .slot_start (slot_start),
    .index_wrap (index_wrap)
  );

  always_comb begin
    slice  = BLANK;
    dp_bit = 1'b0;
    bl_bit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        slice  = seg_in[k*SEG_W +: SEG_W];
        dp_bit = dp_mask[k];
        bl_bit = blank_mask[k];
      end
    end
    fresh = slice;
    if (dp_bit) fresh[DP_BIT] = 1'b0;
    if (bl_bit) fresh = BLANK;
  end

  // The fresh pattern is used directly on the capture cycle so DEAD_CYC=0 works.
  always_comb begin
    pat_d   = slot_start ? fresh : pat_q;
    pwm_now = (slot_cnt == DEAD_V) ? '0 : pwm_q;
    pwm_d   = enable ? pwm_now + 1'b1 : '0;
    drive   = enable && (slot_cnt >= DEAD_V) &&
              ((&brightness) || (pwm_now < brightness));
    seg_d   = drive ? pat_d : BLANK;
    sel_d   = drive ? NUM_DIGITS'(1) << idx : '0;
    wrap_d  = index_wrap;
    tick_d  = wrap_q && enable;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= '0;
      pwm_q  <= '0;
      wrap_q <= 1'b0;
      seg_q  <= BLANK;
      sel_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      pwm_q  <= pwm_d;
      wrap_q <= wrap_d;
      seg_q  <= seg_d;
      sel_q  <= sel_d;
      tick_q <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign digit_sel  = sel_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Self-checking bench for led_scan_driver: arithmetic scan model plus
// directed scenarios with hand-computed expectations.
module tb_led_scan_driver;

  localparam int ND   = 4;
  localparam int SW   = 8;
  localparam int SLOT = 8;
  localparam int DEAD = 1;
  localparam int BW   = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b1;
  logic [ND*SW-1:0] seg_in = 32'hF9A4B0C0;
  logic [ND-1:0]  dp_mask = '0;
  logic [ND-1:0]  blank_mask = '0;
  logic [BW-1:0]  brightness = 2'd3;
  logic [SW-1:0]  seg_out;
  logic [ND-1:0]  digit_sel;
  logic           frame_tick;

  int total = 0;
  int bad = 0;

  int pos = 0;
  int sc, di, pw;
  logic on;
  logic [SW-1:0] cap = '0;
  logic [SW-1:0] e_seg = 8'hFF;
  logic [ND-1:0] e_sel = '0;
  logic          e_tick = 1'b0;

  led_scan_driver #(
    .NUM_DIGITS (ND),
    .SEG_W      (SW),
    .SLOT_CYC   (SLOT),
    .DEAD_CYC   (DEAD),
    .BRIGHT_W   (BW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .seg_in     (seg_in),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .brightness (brightness),
    .seg_out    (seg_out),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] pat_of(input int d);
    logic [SW-1:0] p;
    p = seg_in[d*SW +: SW];
    if (dp_mask[d]) p = p & 8'h7F;
    if (blank_mask[d]) p = 8'hFF;
    return p;
  endfunction

  // Model: pos counts enabled cycles since reset/enable-low.
  always @(posedge clk) begin
    if (!rst_n || !enable) begin
      pos    = 0;
      e_seg  = 8'hFF;
      e_sel  = '0;
      e_tick = 1'b0;
    end else begin
      sc = pos % SLOT;
      di = (pos / SLOT) % ND;
      if (sc == 0) cap = pat_of(di);
      pw = (sc - DEAD) % (1 << BW);
      on = (sc >= DEAD) && (brightness == 2'd3 || pw < int'(brightness));
      e_seg  = on ? cap : 8'hFF;
      e_sel  = on ? ND'(1 << di) : '0;
      e_tick = (pos > 0) && (pos % (SLOT * ND) == 0);
      pos++;
    end
    #1;
    chk("seg_out", 32'(seg_out), 32'(e_seg));
    chk("digit_sel", 32'(digit_sel), 32'(e_sel));
    chk("frame_tick", 32'(frame_tick), 32'(e_tick));
    chk("onehot", 32'($countones(digit_sel) <= 1), 32'd1);
  end

  int on_cnt[ND];
  int n_a, n_b, n_c, ticks;
  logic [7:0] exp_b[ND];

  initial begin
    exp_b[0] = 8'hC0; exp_b[1] = 8'hB0;
    exp_b[2] = 8'hA4; exp_b[3] = 8'hF9;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(seg_out), 32'hFF);
    chk("rst_sel", 32'(digit_sel), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;

    // full brightness scan over two frames
    for (int d = 0; d < ND; d++) on_cnt[d] = 0;
    ticks = 0;
    for (int i = 0; i <= 64; i++) begin
      @(negedge clk);
      if (i == 0) chk("first_dead", 32'(digit_sel), 32'h0);
      if (i == 1) chk("first_on", {digit_sel, seg_out}, {4'b0001, 8'hC0});
      for (int d = 0; d < ND; d++)
        if (digit_sel == ND'(1 << d) && seg_out == exp_b[d]) on_cnt[d]++;
      if (frame_tick) ticks++;
    end
    for (int d = 0; d < ND; d++) chk("on_cycles", on_cnt[d], 14);
    chk("tick_count", ticks, 2);

    // brightness 1: two lit cycles per slot
    brightness = 2'd1;
    n_a = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (digit_sel != 0) n_a++;
    end
    chk("bright1_lit", n_a, 8);

    // brightness 0: fully dark
    brightness = 2'd0;
    n_a = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (digit_sel != 0 || seg_out != 8'hFF) n_a++;
    end
    chk("bright0_lit", n_a, 0);

    // dp and blank masks
    brightness = 2'd3;
    dp_mask    = 4'b0100;
    blank_mask = 4'b0001;
    repeat (32) @(negedge clk);
    n_a = 0; n_b = 0; n_c = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (digit_sel == 4'b0001) n_a++;
      if (digit_sel == 4'b0001 && seg_out != 8'hFF) n_b++;
      if (digit_sel == 4'b0100 && seg_out == 8'h24) n_c++;
    end
    chk("blank_sel_on", n_a, 7);
    chk("blank_seg_ff", n_b, 0);
    chk("dp_digit2", n_c, 7);
    dp_mask    = '0;
    blank_mask = '0;

    // seg_in change at slot count 4 of digit 1
    for (int i = 0; i < 40 && (pos % 32) != 12; i++) @(negedge clk);
    chk("align_d1", pos % 32, 12);
    seg_in = 32'h12345678;
    n_a = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (digit_sel == 4'b0010 && seg_out == 8'hB0) n_a++;
    end
    chk("midslot_hold", n_a, 3);
    n_a = 0; n_b = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (digit_sel == 4'b0010 && seg_out == 8'h56) n_a++;
      if (digit_sel == 4'b0100 && seg_out == 8'h34) n_b++;
    end
    chk("d1_new", n_a, 7);
    chk("d2_new", n_b, 13);

    // enable dropped mid-slot of digit 2
    for (int i = 0; i < 40 && (pos % 32) != 20; i++) @(negedge clk);
    chk("align_d2", pos % 32, 20);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_blank", {digit_sel, seg_out}, {4'b0000, 8'hFF});
    repeat (2) @(negedge clk);
    enable = 1'b1;
    ticks = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 1) chk("reen_d0", {digit_sel, seg_out}, {4'b0001, 8'h78});
      if (frame_tick) ticks++;
    end
    chk("reen_ticks", ticks, 0);

    // asynchronous reset mid-slot
    repeat (13) @(negedge clk);
    chk("pre_rst_lit", 32'(digit_sel != 0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", 32'(seg_out), 32'hFF);
    chk("arst_sel", 32'(digit_sel), 32'h0);
    chk("arst_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 1) chk("post_rst_d0", {digit_sel, seg_out}, {4'b0001, 8'h78});
    end
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
